// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared widths, state encoding and requant helper for the psum stage
// Purpose: common constants and the requantisation function (ReLU, rounding shift, saturate).
// Ports: none (package).
package accel_pkg;

  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One extra bit of headroom so adding the rounding term to a value near
  // +2^31 cannot wrap before the shift.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] sum,
                                               input logic [4:0]              shift,
                                               input logic                    relu);
    logic signed [ACC_W:0] v;
    logic signed [ACC_W:0] rnd;
    logic [OUT_W-1:0]      res;
    v = (relu && sum < 0) ? '0 : {sum[ACC_W-1], sum};
    if (shift != 5'd0) begin
      rnd = (ACC_W+1)'(1) << (shift - 5'd1);
      v   = (v + rnd) >>> shift;
    end
    if (v > (ACC_W+1)'(OUT_MAX))      res = OUT_W'(OUT_MAX);
    else if (v < (ACC_W+1)'(OUT_MIN)) res = OUT_W'(OUT_MIN);
    else                              res = v[OUT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with async active-low reset
// Purpose: small result queue; pop_data always presents the head entry.
// Ports: clk, rst_n; push/push_data write side; pop/pop_data read side;
//        empty flag and occupancy count.
module sync_fifo
  import accel_pkg::*;
#(
  parameter int WIDTH = OUT_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is accepted when a pop frees the head the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psum_requant_stage.sv
// rtl/psum_requant_stage.sv - cross-pass partial-sum accumulation with requant to 8 bits
// Purpose: sums accumulator-tree beats over input-channel passes in a local buffer; on the
//          final pass requantises each sum and queues it for the output writer.
// Ports: clk, rst_n; cfg_start/cfg_num_pos/cfg_num_pass/cfg_shift/cfg_relu tile config;
//        acc_valid/acc_in/acc_ready input stream; out_valid/out_data/out_ready result stream;
//        busy (RUN or DRAIN) and done (one-cycle pulse at end of tile).
module psum_requant_stage
  import accel_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [4:0]       cfg_num_pos,
  input  logic [7:0]       cfg_num_pass,
  input  logic [4:0]       cfg_shift,
  input  logic             cfg_relu,
  input  logic             acc_valid,
  input  logic [ACC_W-1:0] acc_in,
  output logic             acc_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int POS_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state, next_state;
  logic [POS_W-1:0] num_pos, pos;
  logic [7:0]       num_pass, pass;
  logic [4:0]       shift;
  logic             relu;
  logic [ACC_W-1:0] psum_buf [DEPTH];
  logic [ACC_W-1:0] sum;
  logic             post_valid;
  logic [OUT_W-1:0] post_data;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             last_pos, last_pass, fire, start_take, drained;

  assign last_pos   = (pos == num_pos - 1'b1);
  assign last_pass  = (pass == num_pass - 8'd1);
  // Final-pass beats may only be taken when the post register and FIFO together
  // still have room, so a result is never dropped.
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, post_valid};
  assign acc_ready  = (state == RUN) && (!last_pass || occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign fire       = acc_valid && acc_ready;
  assign start_take = (state == IDLE) && cfg_start;
  assign drained    = !post_valid && fifo_empty;
  assign sum        = ((pass == 8'd0) ? '0 : psum_buf[pos[IDX_W-1:0]]) + acc_in;
  assign busy       = (state != IDLE);
  assign out_valid  = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cfg_start) next_state = RUN;
      RUN:     if (fire && last_pos && last_pass) next_state = DRAIN;
      DRAIN:   if (drained) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_pos    <= POS_W'(DEPTH);
      num_pass   <= 8'd1;
      shift      <= '0;
      relu       <= 1'b0;
      pos        <= '0;
      pass       <= '0;
      post_valid <= 1'b0;
      post_data  <= '0;
      done       <= 1'b0;
    end else begin
      done       <= (state == DRAIN) && drained;
      post_valid <= fire && last_pass;
      if (fire && last_pass) post_data <= requant(sum, shift, relu);
      if (start_take) begin
        num_pos  <= (cfg_num_pos == 5'd0 || int'(cfg_num_pos) > DEPTH) ? POS_W'(DEPTH)
                                                                       : POS_W'(cfg_num_pos);
        num_pass <= (cfg_num_pass == 8'd0) ? 8'd1 : cfg_num_pass;
        shift    <= cfg_shift;
        relu     <= cfg_relu;
        pos      <= '0;
        pass     <= '0;
      end else if (fire) begin
        if (last_pos) begin
          pos  <= '0;
          pass <= pass + 8'd1;
        end else begin
          pos  <= pos + 1'b1;
        end
      end
    end
  end

  // Buffer contents need no reset: pass 0 never reads them and overwrites every entry.
  always_ff @(posedge clk) begin
    if (fire && !last_pass) psum_buf[pos[IDX_W-1:0]] <= sum;
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (post_valid),
    .push_data (post_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_psum_requant_stage.sv
// tb/tb_psum_requant_stage.sv - directed self-checking bench for psum_requant_stage
module tb_psum_requant_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [4:0]  cfg_num_pos;
  logic [7:0]  cfg_num_pass;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic        acc_valid;
  logic [31:0] acc_in;
  logic        acc_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  psum_requant_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_num_pos  (cfg_num_pos),
    .cfg_num_pass (cfg_num_pass),
    .cfg_shift    (cfg_shift),
    .cfg_relu     (cfg_relu),
    .acc_valid    (acc_valid),
    .acc_in       (acc_in),
    .acc_ready    (acc_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done)
  );

  // out_ready only changes on negedges, so the handshake is stable at the posedge.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start(input logic [4:0] np, input logic [7:0] npass,
                       input logic [4:0] sh, input logic rl);
    cfg_num_pos  = np;
    cfg_num_pass = npass;
    cfg_shift    = sh;
    cfg_relu     = rl;
    cfg_start    = 1'b1;
    @(negedge clk);
    cfg_start    = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    int n;
    n = 0;
    acc_valid = 1'b1;
    acc_in    = v;
    while (!acc_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("acc_ready_timeout", 32'(n < 100), 32'd1);
    @(negedge clk);
    acc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      chk($sformatf("%s_out%0d", tag, i),
          (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
    got.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_acc_ready"}, 32'(acc_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
  endtask

  initial begin
    logic [31:0] vals [8];
    rst_n = 1'b0; cfg_start = 1'b0; cfg_num_pos = '0; cfg_num_pass = '0;
    cfg_shift = '0; cfg_relu = 1'b0; acc_valid = 1'b0; acc_in = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single pass, no shift: values pass straight through.
    start(5'd2, 8'd1, 5'd0, 1'b0);
    send(32'd5);
    send(-32'sd3);
    wait_done("t1");
    exp_q = '{8'h05, 8'hFD};
    chk_outs("t1");

    // Two-cycle latency from accepted final-pass beat to out_valid.
    out_ready = 1'b0;
    start(5'd1, 8'd1, 5'd0, 1'b0);
    send(32'd9);
    chk("lat_t1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_t2_valid", 32'(out_valid), 32'd1);
    chk("lat_t2_data",  32'(out_data),  32'h09);
    chk("lat_busy",     32'(busy),      32'd1);
    out_ready = 1'b1;
    wait_done("lat");
    exp_q = '{8'h09};
    chk_outs("lat");

    // Three passes: 600 >>> 2 rounds to 150, saturates to 127.
    start(5'd1, 8'd3, 5'd2, 1'b0);
    send(32'd100);
    send(32'd200);
    send(32'd300);
    wait_done("t2");
    exp_q = '{8'h7F};
    chk_outs("t2");

    // ReLU clamps -50; (6+2)>>2 = 2.
    start(5'd2, 8'd1, 5'd2, 1'b1);
    send(-32'sd50);
    send(32'd6);
    wait_done("t3");
    exp_q = '{8'h00, 8'h02};
    chk_outs("t3");

    // Backpressure: room for exactly four results (FIFO plus post register).
    vals = '{32'd1, -32'sd2, 32'd3, -32'sd4, 32'd127, 32'd128, -32'sd128, -32'sd129};
    out_ready = 1'b0;
    start(5'd8, 8'd1, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) send(vals[i]);
    chk("bp_ready_after4", 32'(acc_ready), 32'd0);
    @(negedge clk);
    chk("bp_ready_held", 32'(acc_ready), 32'd0);
    chk("bp_head_valid", 32'(out_valid), 32'd1);
    chk("bp_head_data",  32'(out_data),  32'h01);
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) send(vals[i]);
    wait_done("bp");
    exp_q = '{8'h01, 8'hFE, 8'h03, 8'hFC, 8'h7F, 8'h7F, 8'h80, 8'h80};
    chk_outs("bp");

    // Asynchronous reset in the middle of pass 1 of 2.
    start(5'd2, 8'd2, 5'd0, 1'b0);
    send(32'd11);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    @(negedge clk);
    start(5'd1, 8'd1, 5'd0, 1'b0);
    send(32'd7);
    wait_done("postrst");
    exp_q = '{8'h07};
    chk_outs("postrst");

    // cfg_start while busy must not restart or relatch config.
    start(5'd2, 8'd1, 5'd0, 1'b0);
    send(32'd1);
    cfg_num_pos = 5'd1;
    cfg_start   = 1'b1;
    @(negedge clk);
    cfg_start   = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    send(32'd2);
    wait_done("restart");
    exp_q = '{8'h01, 8'h02};
    chk_outs("restart");

    // Zero config clamps to one pass of DEPTH positions.
    start(5'd0, 8'd0, 5'd0, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      send(32'(i * 3 - 20));
      exp_q.push_back(8'(i * 3 - 20));
    end
    wait_done("clamp");
    chk_outs("clamp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
